// File: rtl/mac_acc_pipe.sv
// ----------------------------------------------------------------------------
// mac_acc_pipe
//   Signed multiply-accumulate with vector framing. It is used as the
//   per-PE accumulator in the matrix-multiplier datapath. The unit forms one
//   input x weight product per accepted term and adds it into an accumulator.
//   It emits one result per vector. Overflow can clamp or wrap, and the
//   overflow flag is sticky across the whole vector.
//
//   Pipeline:
//     p1 : registered product, valid and last of the accepted term
//     p2 : accumulator, term counter, per-vector overflow; the result
//          registers are loaded from p2 on the final term of a vector
//
// Ports:
//   clk_i         rising-edge clock
//   rstn_i        asynchronous active-low reset
//   dsp_enable_i  clock enable for every stage (low = hold)
//   clear_i       synchronous flush of accumulator, counter, flags, valids
//   dsp_valid_i   operand pair valid
//   dsp_last_i    final term of the current vector (qualified by valid)
//   dsp_input_i   signed input operand  [IN_W]
//   dsp_weight_i  signed weight operand [W_W]
//   dsp_output_o  signed vector result  [ACC_W]
//   dsp_valid_o   one-cycle result strobe
//   dsp_count_o   number of terms in the emitted vector [CNT_W]
//   overflow_o    overflow seen anywhere in the emitted vector
// ----------------------------------------------------------------------------
module mac_acc_pipe #(
   parameter int IN_W     = 8,
   parameter int W_W      = 8,
   parameter int ACC_W    = 32,
   parameter int SATURATE = 1,
   parameter int MAX_LEN  = 0,
   parameter int CNT_W    = 16
) (
   input  logic                    clk_i,
   input  logic                    rstn_i,
   input  logic                    dsp_enable_i,
   input  logic                    clear_i,
   input  logic                    dsp_valid_i,
   input  logic                    dsp_last_i,
   input  logic signed [IN_W-1:0]  dsp_input_i,
   input  logic signed [W_W-1:0]   dsp_weight_i,
   output logic signed [ACC_W-1:0] dsp_output_o,
   output logic                    dsp_valid_o,
   output logic [CNT_W-1:0]        dsp_count_o,
   output logic                    overflow_o
);

   localparam int P_W = IN_W + W_W;
   localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   generate
      if (ACC_W < P_W) begin : g_width_check
         $error("mac_acc_pipe: ACC_W must be >= IN_W + W_W");
      end
   endgenerate

   // An overflowed sum has its two top bits disagreeing; the top bit
   // then tells which bound was crossed.
   function automatic logic ovf_fn(input logic signed [ACC_W:0] sum);
      return sum[ACC_W] != sum[ACC_W-1];
   endfunction

   function automatic logic signed [ACC_W-1:0] clamp_fn(input logic signed [ACC_W:0] sum);
      logic signed [ACC_W-1:0] res;
      res = sum[ACC_W-1:0];
      if (ovf_fn(sum) && (SATURATE != 0)) begin
         res = sum[ACC_W] ? ACC_MIN : ACC_MAX;
      end
      return res;
   endfunction

   logic signed [P_W-1:0]   prod_p1_q, prod_p1_d;
   logic                    vld_p1_q, vld_p1_d;
   logic                    last_p1_q, last_p1_d;
   logic signed [ACC_W-1:0] acc_p2_q, acc_p2_d;
   logic [CNT_W-1:0]        cnt_p2_q, cnt_p2_d;
   logic                    ovf_p2_q, ovf_p2_d;
   logic signed [ACC_W-1:0] res_q, res_d;
   logic [CNT_W-1:0]        res_cnt_q, res_cnt_d;
   logic                    res_ovf_q, res_ovf_d;
   logic                    res_vld_q, res_vld_d;

   logic signed [P_W-1:0]   in_ext, w_ext, prod_mul;
   logic signed [ACC_W:0]   prod_ext, acc_ext, sum_p2;
   logic signed [ACC_W-1:0] sum_fin;
   logic                    term_ovf;
   logic [CNT_W-1:0]        cnt_inc;
   logic                    max_hit;
   logic                    last_eff;

   // ---- stage p1: full-precision signed product ----
   assign in_ext   = P_W'(dsp_input_i);
   assign w_ext    = P_W'(dsp_weight_i);
   assign prod_mul = in_ext * w_ext;

   // ---- stage p2: one guard bit above ACC_W exposes overflow ----
   assign prod_ext = {{(ACC_W+1-P_W){prod_p1_q[P_W-1]}}, prod_p1_q};
   assign acc_ext  = {acc_p2_q[ACC_W-1], acc_p2_q};
   assign sum_p2   = acc_ext + prod_ext;
   assign sum_fin  = clamp_fn(sum_p2);
   assign term_ovf = ovf_fn(sum_p2);

   // Counter sticks at all-ones; accumulation carries on regardless.
   assign cnt_inc  = (cnt_p2_q == '1) ? cnt_p2_q : cnt_p2_q + CNT_W'(1);
   assign max_hit  = (MAX_LEN > 0) && ((32'(cnt_p2_q) + 32'd1) == 32'(MAX_LEN));
   assign last_eff = last_p1_q | max_hit;

   always_comb begin
      prod_p1_d = prod_p1_q;
      vld_p1_d  = vld_p1_q;
      last_p1_d = last_p1_q;
      acc_p2_d  = acc_p2_q;
      cnt_p2_d  = cnt_p2_q;
      ovf_p2_d  = ovf_p2_q;
      res_d     = res_q;
      res_cnt_d = res_cnt_q;
      res_ovf_d = res_ovf_q;
      res_vld_d = res_vld_q;
      if (clear_i) begin
         vld_p1_d  = 1'b0;
         last_p1_d = 1'b0;
         acc_p2_d  = '0;
         cnt_p2_d  = '0;
         ovf_p2_d  = 1'b0;
         res_d     = '0;
         res_cnt_d = '0;
         res_ovf_d = 1'b0;
         res_vld_d = 1'b0;
      end else if (dsp_enable_i) begin
         prod_p1_d = prod_mul;
         vld_p1_d  = dsp_valid_i;
         last_p1_d = dsp_valid_i & dsp_last_i;
         res_vld_d = 1'b0;
         if (vld_p1_q) begin
            if (last_eff) begin
               // Close the vector and restart so the next term starts from 0.
               acc_p2_d  = '0;
               cnt_p2_d  = '0;
               ovf_p2_d  = 1'b0;
               res_d     = sum_fin;
               res_cnt_d = cnt_inc;
               res_ovf_d = ovf_p2_q | term_ovf;
               res_vld_d = 1'b1;
            end else begin
               acc_p2_d  = sum_fin;
               cnt_p2_d  = cnt_inc;
               ovf_p2_d  = ovf_p2_q | term_ovf;
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         prod_p1_q <= '0;
         vld_p1_q  <= 1'b0;
         last_p1_q <= 1'b0;
         acc_p2_q  <= '0;
         cnt_p2_q  <= '0;
         ovf_p2_q  <= 1'b0;
         res_q     <= '0;
         res_cnt_q <= '0;
         res_ovf_q <= 1'b0;
         res_vld_q <= 1'b0;
      end else begin
         prod_p1_q <= prod_p1_d;
         vld_p1_q  <= vld_p1_d;
         last_p1_q <= last_p1_d;
         acc_p2_q  <= acc_p2_d;
         cnt_p2_q  <= cnt_p2_d;
         ovf_p2_q  <= ovf_p2_d;
         res_q     <= res_d;
         res_cnt_q <= res_cnt_d;
         res_ovf_q <= res_ovf_d;
         res_vld_q <= res_vld_d;
      end
   end

   // A strobe caught by a stall is held in res_vld_q and shown only once
   // enable returns, so it is seen in exactly one enabled cycle.
   assign dsp_valid_o  = res_vld_q & dsp_enable_i;
   assign dsp_output_o = res_q;
   assign dsp_count_o  = res_cnt_q;
   assign overflow_o   = res_ovf_q;

endmodule

// File: tb/tb_mac_acc_pipe.sv
// ----------------------------------------------------------------------------
// tb_mac_acc_pipe
//   Four mac_acc_pipe instances share one stimulus bus. Instance 0 uses the
//   default parameters. Instance 1 uses a 16-bit accumulator with saturation.
//   Instance 2 uses a 16-bit accumulator with wrap. Instance 3 uses
//   MAX_LEN=4. dsp_valid_i is steered to a single instance at a time.
//   Expected results are queued per instance when a vector is issued.
//   A negedge monitor pops and compares them whenever that instance strobes.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mac_acc_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rstn = 1'b1;
   logic en   = 1'b1;
   logic clr  = 1'b0;
   logic vin  = 1'b0;
   logic last = 1'b0;
   logic signed [7:0] a = '0;
   logic signed [7:0] b = '0;
   int   sel = 0;
   logic [3:0] v;
   assign v = vin ? (4'b0001 << sel) : 4'b0000;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic signed [31:0] o0, o3;
   logic signed [15:0] o1, o2;
   logic [15:0] c0, c1, c2, c3;
   logic vo0, vo1, vo2, vo3, f0, f1, f2, f3;

   mac_acc_pipe u0 (
      .clk_i(clk), .rstn_i(rstn), .dsp_enable_i(en), .clear_i(clr),
      .dsp_valid_i(v[0]), .dsp_last_i(last), .dsp_input_i(a), .dsp_weight_i(b),
      .dsp_output_o(o0), .dsp_valid_o(vo0), .dsp_count_o(c0), .overflow_o(f0));
   mac_acc_pipe #(.ACC_W(16), .SATURATE(1)) u1 (
      .clk_i(clk), .rstn_i(rstn), .dsp_enable_i(en), .clear_i(clr),
      .dsp_valid_i(v[1]), .dsp_last_i(last), .dsp_input_i(a), .dsp_weight_i(b),
      .dsp_output_o(o1), .dsp_valid_o(vo1), .dsp_count_o(c1), .overflow_o(f1));
   mac_acc_pipe #(.ACC_W(16), .SATURATE(0)) u2 (
      .clk_i(clk), .rstn_i(rstn), .dsp_enable_i(en), .clear_i(clr),
      .dsp_valid_i(v[2]), .dsp_last_i(last), .dsp_input_i(a), .dsp_weight_i(b),
      .dsp_output_o(o2), .dsp_valid_o(vo2), .dsp_count_o(c2), .overflow_o(f2));
   mac_acc_pipe #(.MAX_LEN(4)) u3 (
      .clk_i(clk), .rstn_i(rstn), .dsp_enable_i(en), .clear_i(clr),
      .dsp_valid_i(v[3]), .dsp_last_i(last), .dsp_input_i(a), .dsp_weight_i(b),
      .dsp_output_o(o3), .dsp_valid_o(vo3), .dsp_count_o(c3), .overflow_o(f3));

   typedef struct {
      int val;
      int cnt;
      bit ovf;
   } exp_t;
   exp_t q0[$], q1[$], q2[$], q3[$];

   int checks = 0;
   int errors = 0;
   int strobe_cyc0 = -1;

   task automatic chk_eq(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic push(input int d, input int val, input int cnt, input bit ovf);
      exp_t e;
      e.val = val; e.cnt = cnt; e.ovf = ovf;
      case (d)
         0: q0.push_back(e);
         1: q1.push_back(e);
         2: q2.push_back(e);
         default: q3.push_back(e);
      endcase
   endtask

   task automatic mon(input int d, input int val, input int cnt, input bit ovf);
      exp_t e;
      bit   have;
      have = 1'b0;
      case (d)
         0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
         1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
         2: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
         default: if (q3.size() > 0) begin e = q3.pop_front(); have = 1'b1; end
      endcase
      if (!have) begin
         checks++;
         errors++;
         $display("FAIL unexpected_strobe dut%0d: got result %0d count %0d, expected no strobe",
                  d, val, cnt);
      end else begin
         chk_eq($sformatf("dut%0d_output", d), val, e.val);
         chk_eq($sformatf("dut%0d_count", d), cnt, e.cnt);
         chk_eq($sformatf("dut%0d_overflow", d), int'(ovf), int'(e.ovf));
      end
   endtask

   // Monitor: compares every presented result against the scoreboard.
   always @(negedge clk) begin
      if (vo0) begin
         strobe_cyc0 = cyc;
         mon(0, int'(o0), int'(c0), f0);
      end
      if (vo1) mon(1, int'(o1), int'(c1), f1);
      if (vo2) mon(2, int'(o2), int'(c2), f2);
      if (vo3) mon(3, int'(o3), int'(c3), f3);
   end

   task automatic term(input int d, input int ia, input int ib, input bit il);
      sel = d; a = 8'(ia); b = 8'(ib); last = il; vin = 1'b1;
      @(posedge clk); #1;
      vin = 1'b0; last = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic chk_all_zero(input string tag);
      chk_eq({tag, "_out0"}, int'(o0), 0);  chk_eq({tag, "_cnt0"}, int'(c0), 0);
      chk_eq({tag, "_ovf0"}, int'(f0), 0);  chk_eq({tag, "_vld0"}, int'(vo0), 0);
      chk_eq({tag, "_out1"}, int'(o1), 0);  chk_eq({tag, "_cnt1"}, int'(c1), 0);
      chk_eq({tag, "_ovf1"}, int'(f1), 0);  chk_eq({tag, "_vld1"}, int'(vo1), 0);
      chk_eq({tag, "_out2"}, int'(o2), 0);  chk_eq({tag, "_cnt2"}, int'(c2), 0);
      chk_eq({tag, "_ovf2"}, int'(f2), 0);  chk_eq({tag, "_vld2"}, int'(vo2), 0);
      chk_eq({tag, "_out3"}, int'(o3), 0);  chk_eq({tag, "_cnt3"}, int'(c3), 0);
      chk_eq({tag, "_ovf3"}, int'(f3), 0);  chk_eq({tag, "_vld3"}, int'(vo3), 0);
   endtask

   // Waits (bounded) for a dut0 strobe and returns cycles since accept_cyc.
   task automatic wait_strobe0(input int accept_cyc, output int delta);
      delta = -1;
      for (int i = 0; i < 20; i++) begin
         if (strobe_cyc0 >= 0) break;
         idle(1);
      end
      if (strobe_cyc0 < 0) begin
         checks++;
         errors++;
         $display("FAIL strobe_timeout dut0: got no strobe, expected one within 20 cycles");
      end else begin
         delta = strobe_cyc0 - accept_cyc;
      end
   endtask

   initial begin
      int acc_cyc, d_ref, d_stall;
      #1 rstn = 1'b0;
      #1 chk_all_zero("reset");
      @(posedge clk); @(posedge clk); #1;
      rstn = 1'b1;
      idle(1);

      // Default vector: 12 - 10 - 7 = -5; a stray last without valid is ignored.
      push(0, -5, 3, 1'b0);
      term(0, 3, 4, 1'b0);
      last = 1'b1; idle(1); last = 1'b0;
      term(0, -2, 5, 1'b0);
      term(0, 7, -1, 1'b1);
      idle(4);

      // Back-to-back vectors with no gap.
      push(0, 1, 1, 1'b0);
      push(0, 7, 2, 1'b0);
      term(0, 1, 1, 1'b1);
      term(0, 2, 3, 1'b0);
      term(0, -1, -1, 1'b1);
      idle(4);

      // Reference latency, then the same with a 3-cycle stall on the last term.
      strobe_cyc0 = -1;
      push(0, 25, 1, 1'b0);
      term(0, 5, 5, 1'b1);
      acc_cyc = cyc;
      wait_strobe0(acc_cyc, d_ref);
      idle(2);
      strobe_cyc0 = -1;
      push(0, 36, 1, 1'b0);
      term(0, 6, 6, 1'b1);
      acc_cyc = cyc;
      en = 1'b0;
      sel = 0; a = 8'sd100; b = 8'sd100; last = 1'b1; vin = 1'b1;
      idle(3);
      vin = 1'b0; last = 1'b0; en = 1'b1;
      wait_strobe0(acc_cyc, d_stall);
      chk_eq("stall_delay", d_stall, d_ref + 3);
      idle(2);

      // Clear with a last term in flight and a new term offered the same cycle.
      term(0, 4, 4, 1'b1);
      clr = 1'b1; sel = 0; a = 8'sd9; b = 8'sd9; vin = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0; vin = 1'b0;
      chk_eq("clear_out", int'(o0), 0);
      chk_eq("clear_cnt", int'(c0), 0);
      chk_eq("clear_ovf", int'(f0), 0);
      chk_eq("clear_vld", int'(vo0), 0);
      idle(3);
      term(0, 10, 10, 1'b0);
      clr = 1'b1; idle(1); clr = 1'b0;
      push(0, 5, 2, 1'b0);
      term(0, 2, 2, 1'b0);
      term(0, 1, 1, 1'b1);
      idle(4);

      // 16-bit saturating: clamps high, restarts clean, clamps low.
      push(1, 32767, 5, 1'b1);
      push(1, 1, 1, 1'b0);
      push(1, -32768, 5, 1'b1);
      for (int i = 0; i < 5; i++) term(1, 127, 127, i == 4);
      term(1, 1, 1, 1'b1);
      for (int i = 0; i < 5; i++) term(1, -128, 127, i == 4);
      idle(4);

      // 16-bit wrapping.
      push(2, 15109, 5, 1'b1);
      push(2, -15744, 5, 1'b1);
      for (int i = 0; i < 5; i++) term(2, 127, 127, i == 4);
      for (int i = 0; i < 5; i++) term(2, -128, 127, i == 4);
      idle(4);

      // MAX_LEN=4: forced split, then a redundant last on the 4th term.
      push(3, 8, 4, 1'b0);
      push(3, 6, 3, 1'b0);
      for (int i = 0; i < 7; i++) term(3, 1, 2, i == 6);
      idle(4);
      push(3, 8, 4, 1'b0);
      push(3, 1, 1, 1'b0);
      for (int i = 0; i < 4; i++) term(3, 1, 2, i == 3);
      term(3, 1, 1, 1'b1);
      idle(4);

      // Asynchronous reset mid-vector.
      term(0, 3, 3, 1'b0);
      #3 rstn = 1'b0;
      #1 chk_all_zero("async_reset");
      @(posedge clk); #1;
      rstn = 1'b1;
      idle(4);
      push(0, 4, 1, 1'b0);
      term(0, 2, 2, 1'b1);
      idle(4);

      chk_eq("pending_dut0", q0.size(), 0);
      chk_eq("pending_dut1", q1.size(), 0);
      chk_eq("pending_dut2", q2.size(), 0);
      chk_eq("pending_dut3", q3.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: got time %0t, expected completion earlier", $time);
      $fatal(1, "timeout");
   end

endmodule
